// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, issues one word fetch at a time and pushes
// {err, pc, inst} into the instruction queue; redirects drop any in-flight response.
module inst_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     ENTRY_W  = XLEN + 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  input  logic               imem_rsp_err,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [ENTRY_W-1:0] fifo_wr_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;

  logic [XLEN-1:0] redirect_tgt;
  logic            req_hs;
  logic            rsp_in_wait;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign req_hs       = (state_q == S_REQ) && !fifo_full && imem_req_ready;
  assign rsp_in_wait  = (state_q == S_WAIT) && imem_rsp_valid;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  // Next state; redirect outranks every other event outside IDLE
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (req_hs) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end else if (req_hs) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            pc_d    = req_pc_q + XLEN'(4);
            state_d = imem_rsp_err ? S_HALT : S_REQ;
          end
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the push is combinational with the response
  always_comb begin
    imem_req_valid = 1'b0;
    fifo_wr_en     = 1'b0;
    fifo_wr_data   = '0;
    unique case (state_q)
      S_REQ:  imem_req_valid = !fifo_full;
      S_WAIT: begin
        if (rsp_in_wait && !drop_q && !redirect_valid) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = ENTRY_W'({imem_rsp_err, req_pc_q, imem_rsp_data});
        end
      end
      default: ;
    endcase
  end

  assign imem_req_addr = pc_q;

  // Single outstanding request plus full-gated issue makes this unreachable
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
                                        !(fifo_wr_en && fifo_full));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: sequential fetch, queue-full stall,
// redirects in every state, bus-error halt, async reset mid-fetch and PC wrap.
module tb_inst_fetch;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = XLEN + 33;

  logic               clk;
  logic               rst;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [31:0]        imem_rsp_data;
  logic               imem_rsp_err;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [ENTRY_W-1:0] fifo_wr_data;

  int total = 0;
  int bad   = 0;

  inst_fetch #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .ENTRY_W(ENTRY_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .fifo_full      (fifo_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compares outputs; addr only when a request is expected, data only when a push is expected
  task automatic expect_out(input string tag, input logic v, input logic [XLEN-1:0] a,
                            input logic w, input logic [ENTRY_W-1:0] d);
    #1;
    total++;
    assert (imem_req_valid === v) else begin
      bad++;
      $error("FAIL %s.req_valid got=%0b want=%0b", tag, imem_req_valid, v);
    end
    if (v) begin
      total++;
      assert (imem_req_addr === a) else begin
        bad++;
        $error("FAIL %s.req_addr got=%h want=%h", tag, imem_req_addr, a);
      end
    end
    total++;
    assert (fifo_wr_en === w) else begin
      bad++;
      $error("FAIL %s.wr_en got=%0b want=%0b", tag, fifo_wr_en, w);
    end
    if (w) begin
      total++;
      assert (fifo_wr_data === d) else begin
        bad++;
        $error("FAIL %s.wr_data got=%h want=%h", tag, fifo_wr_data, d);
      end
    end
  endtask

  task automatic expect_data_zero(input string tag);
    total++;
    assert (fifo_wr_data === '0) else begin
      bad++;
      $error("FAIL %s.wr_data got=%h want=0", tag, fifo_wr_data);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] ent(input logic e, input logic [XLEN-1:0] p,
                                             input logic [31:0] i);
    return {e, p, i};
  endfunction

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    fifo_full      = 1'b0;

    // Reset state
    #1;
    expect_out("reset", 1'b0, '0, 1'b0, '0);
    expect_data_zero("reset");
    cyc();
    cyc();
    rst = 1'b1;
    expect_out("idle", 1'b0, '0, 1'b0, '0);

    // 1: sequential fetch, 1-cycle memory
    cyc();
    expect_out("t1.req0", 1'b1, 32'h0, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0000;
    expect_out("t1.push0", 1'b0, '0, 1'b1, ent(1'b0, 32'h0, 32'hA000_0000));
    cyc(); imem_rsp_valid = 1'b0;
    expect_out("t1.req4", 1'b1, 32'h4, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0001;
    expect_out("t1.push4", 1'b0, '0, 1'b1, ent(1'b0, 32'h4, 32'hA000_0001));
    cyc(); imem_rsp_valid = 1'b0;
    expect_out("t1.req8", 1'b1, 32'h8, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0002;
    expect_out("t1.push8", 1'b0, '0, 1'b1, ent(1'b0, 32'h8, 32'hA000_0002));
    cyc(); imem_rsp_valid = 1'b0;

    // 2: queue full holds the request off
    fifo_full = 1'b1;
    expect_out("t2.full0", 1'b0, '0, 1'b0, '0);
    cyc();
    expect_out("t2.full1", 1'b0, '0, 1'b0, '0);
    cyc();
    expect_out("t2.full2", 1'b0, '0, 1'b0, '0);
    fifo_full = 1'b0;
    expect_out("t2.release", 1'b1, 32'hC, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0003;
    expect_out("t2.pushC", 1'b0, '0, 1'b1, ent(1'b0, 32'hC, 32'hA000_0003));
    cyc(); imem_rsp_valid = 1'b0;

    // 5: bus error halts until redirect
    expect_out("t5.req10", 1'b1, 32'h10, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    expect_out("t5.pusherr", 1'b0, '0, 1'b1, ent(1'b1, 32'h10, 32'hDEAD_BEEF));
    cyc(); imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_rsp_valid = (i == 5);
      expect_out("t5.halt", 1'b0, '0, 1'b0, '0);
      cyc();
    end
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    expect_out("t5.redir", 1'b0, '0, 1'b0, '0);
    cyc(); redirect_valid = 1'b0;
    expect_out("t5.req40", 1'b1, 32'h40, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0005;
    expect_out("t5.push40", 1'b0, '0, 1'b1, ent(1'b0, 32'h40, 32'hA000_0005));
    cyc(); imem_rsp_valid = 1'b0;

    // 3: redirect while waiting, stale response 3 cycles later is dropped
    expect_out("t3.req44", 1'b1, 32'h44, 1'b0, '0);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    expect_out("t3.redir", 1'b0, '0, 1'b0, '0);
    cyc(); redirect_valid = 1'b0;
    expect_out("t3.wait1", 1'b0, '0, 1'b0, '0);
    cyc();
    expect_out("t3.wait2", 1'b0, '0, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5757_5757;
    expect_out("t3.stale", 1'b0, '0, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b0;
    expect_out("t3.req100", 1'b1, 32'h100, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0006;
    expect_out("t3.push100", 1'b0, '0, 1'b1, ent(1'b0, 32'h100, 32'hA000_0006));
    cyc(); imem_rsp_valid = 1'b0;

    // 4a: redirect coincident with response suppresses the push
    expect_out("t4a.req104", 1'b1, 32'h104, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5757_5757;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    expect_out("t4a.nopush", 1'b0, '0, 1'b0, '0);
    expect_data_zero("t4a.nopush");
    cyc(); imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    expect_out("t4a.req200", 1'b1, 32'h200, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0007;
    expect_out("t4a.push200", 1'b0, '0, 1'b1, ent(1'b0, 32'h200, 32'hA000_0007));
    cyc(); imem_rsp_valid = 1'b0;

    // 4b: redirect coincident with request handshake drops one response
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    expect_out("t4b.req204", 1'b1, 32'h204, 1'b0, '0);
    cyc(); redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5757_5757;
    expect_out("t4b.drop", 1'b0, '0, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b0;
    expect_out("t4b.req300", 1'b1, 32'h300, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0008;
    expect_out("t4b.push300", 1'b0, '0, 1'b1, ent(1'b0, 32'h300, 32'hA000_0008));
    cyc(); imem_rsp_valid = 1'b0;

    // 4c: redirect in REQ without handshake retargets the next request
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    expect_out("t4c.old304", 1'b1, 32'h304, 1'b0, '0);
    cyc(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
    expect_out("t4c.req400", 1'b1, 32'h400, 1'b0, '0);
    cyc();

    // 6: async reset mid-WAIT, late response ignored
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5757_5757;
    expect_out("t6.rst", 1'b0, '0, 1'b0, '0);
    expect_data_zero("t6.rst");
    cyc();
    expect_out("t6.rsthold", 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    cyc();
    expect_out("t6.req0", 1'b1, 32'h0, 1'b0, '0);
    imem_rsp_valid = 1'b0;
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_0009;
    expect_out("t6.push0", 1'b0, '0, 1'b1, ent(1'b0, 32'h0, 32'hA000_0009));
    cyc(); imem_rsp_valid = 1'b0;

    // 6b: PC wraps from the top of the address space
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    expect_out("t6.wrapredir", 1'b1, 32'h4, 1'b0, '0);
    cyc(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
    expect_out("t6.reqtop", 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_000A;
    expect_out("t6.pushtop", 1'b0, '0, 1'b1, ent(1'b0, 32'hFFFF_FFFC, 32'hA000_000A));
    cyc(); imem_rsp_valid = 1'b0;
    expect_out("t6.wrap0", 1'b1, 32'h0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
